afifo_sc: RTL and testbench



---
 rtl/afifo_sc_ram.sv | 35 +++
 rtl/afifo_sc.sv | 67 ++++++
 tb/tb_afifo_sc.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/afifo_sc_ram.sv
// rtl/afifo_sc_ram.sv - simple dual-port RAM, one write port and one registered read port
module afifo_sc_ram #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     rd_en,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Array has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/afifo_sc.sv
// rtl/afifo_sc.sv - single-clock FIFO with registered read data; AFIFO_SC_COUNT_EN adds an occupancy port
module afifo_sc #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     wr_en,
    input  logic                     rd_en,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     full,
    output logic                     empty
`ifdef AFIFO_SC_COUNT_EN
    ,
    output logic [ADDRESS_WIDTH:0]   count
`endif
);

    localparam int PTR_W = ADDRESS_WIDTH + 1;

    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             wr_accept;
    logic             rd_accept;

    // The extra pointer bit tells a full buffer apart from an empty one.
    assign empty = (wptr == rptr);
    assign full  = (wptr[ADDRESS_WIDTH] != rptr[ADDRESS_WIDTH]) &&
                   (wptr[ADDRESS_WIDTH-1:0] == rptr[ADDRESS_WIDTH-1:0]);

    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;

`ifdef AFIFO_SC_COUNT_EN
    assign count = wptr - rptr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_accept) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (rd_accept) begin
                rptr <= rptr + PTR_W'(1);
            end
        end
    end

    afifo_sc_ram #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_accept),
        .wr_addr (wptr[ADDRESS_WIDTH-1:0]),
        .wr_data (data_in),
        .rd_en   (rd_accept),
        .rd_addr (rptr[ADDRESS_WIDTH-1:0]),
        .rd_data (data_out)
    );

endmodule

// File: tb/tb_afifo_sc.sv
// tb/tb_afifo_sc.sv - scoreboard bench for afifo_sc at depth 4
module tb_afifo_sc;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
`ifdef AFIFO_SC_COUNT_EN
    logic [AW:0]   count;
`endif

    afifo_sc #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
`ifdef AFIFO_SC_COUNT_EN
        ,
        .count    (count)
`endif
    );

    always #5 clk = ~clk;

    logic [DW-1:0] model[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_data = '0;
    logic          mon_en = 1'b0;
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: after each edge, compare read data against the scoreboard and flags against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                last_data = exp_q.pop_front();
                chk("read_data", int'(data_out), int'(last_data));
            end else begin
                chk("data_hold", int'(data_out), int'(last_data));
            end
            chk("empty", int'(empty), int'(model.size() == 0));
            chk("full", int'(full), int'(model.size() == DEPTH));
`ifdef AFIFO_SC_COUNT_EN
            chk("count", int'(count), model.size());
`endif
        end
    end

    task automatic step(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
        logic acc_r;
        logic acc_w;
        @(negedge clk);
        #1;
        rst     = r;
        wr_en   = w;
        rd_en   = rd;
        data_in = d;
        acc_r   = rd && (model.size() > 0);
        acc_w   = w && (model.size() < DEPTH);
        @(posedge clk);
        #1;
        if (r) begin
            model.delete();
            exp_q.delete();
            last_data = '0;
        end else begin
            if (acc_r) exp_q.push_back(model.pop_front());
            if (acc_w) model.push_back(d);
        end
        mon_en = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        // Reset held two cycles, then a read while empty.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        idle(1);

        // Single word.
        step(1'b0, 1'b1, 1'b0, 8'hA5);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        idle(1);

        // Fill, overflow attempt, drain.
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
        step(1'b0, 1'b1, 1'b0, 8'h05);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);

        // Simultaneous at full: read wins, write dropped.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h41 + i));
        step(1'b0, 1'b1, 1'b1, 8'h77);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'h00);

        // Simultaneous at two entries: both accepted.
        step(1'b0, 1'b1, 1'b0, 8'h61);
        step(1'b0, 1'b1, 1'b0, 8'h62);
        step(1'b0, 1'b1, 1'b1, 8'h63);
        step(1'b0, 1'b1, 1'b1, 8'h64);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);

        // Wrap-around stream 0x10..0x23 with occupancy kept at most 3.
        step(1'b0, 1'b1, 1'b0, 8'h10);
        step(1'b0, 1'b1, 1'b0, 8'h11);
        for (int i = 8'h12; i <= 8'h23; i++) step(1'b0, 1'b1, 1'b1, 8'(i));
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);

        // Reset mid-operation, then the FIFO is usable again.
        step(1'b0, 1'b1, 1'b0, 8'h31);
        step(1'b0, 1'b1, 1'b0, 8'h32);
        step(1'b0, 1'b1, 1'b0, 8'h33);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h3C);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        idle(2);
        chk("final_data", int'(data_out), 8'h3C);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
